// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link: word width, comma word, counter widths, scheduler states.
package serial_link_pkg;

  localparam int unsigned WORD_W          = 8;
  localparam int unsigned BIT_CNT_W       = 3;
  localparam int unsigned TRAIN_CNT_W     = 4;
  localparam int unsigned TRAIN_WORDS_DEF = 4;
  localparam logic [WORD_W-1:0] IDLE_WORD_DEF = 8'hBC;

  typedef enum logic {
    TRAIN = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/paralelo_serial.sv
// Word-to-bit serializer: MSB-first, back-to-back words, load strobe on the last bit of each word.
module paralelo_serial
  import serial_link_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_WORD = IDLE_WORD_DEF
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [WORD_W-1:0] load_word,
  input  logic              load_lane,
  input  logic              load_idle,
  output logic              data_out,
  output logic              word_start,
  output logic              lane_out,
  output logic              idle_out,
  output logic              load_slot_c
);

  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [WORD_W-1:0]    word_q;
  logic                 word_lane;
  logic                 word_idle;

  assign load_slot_c = (bit_cnt == BIT_CNT_W'(WORD_W - 1));

  // Lane/idle tags travel with the word and surface together with its bit 7.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      bit_cnt    <= '0;
      word_q     <= RESET_WORD;
      word_lane  <= 1'b0;
      word_idle  <= 1'b1;
      data_out   <= 1'b0;
      word_start <= 1'b0;
      lane_out   <= 1'b0;
      idle_out   <= 1'b1;
    end else begin
      data_out   <= word_q[~bit_cnt];
      word_start <= (bit_cnt == '0);
      bit_cnt    <= bit_cnt + BIT_CNT_W'(1);
      if (bit_cnt == '0) begin
        lane_out <= word_lane;
        idle_out <= word_idle;
      end
      if (load_slot_c) begin
        word_q    <= load_word;
        word_lane <= load_lane;
        word_idle <= load_idle;
      end
    end
  end

endmodule

// File: rtl/arbitro_serial_tx.sv
// Serial transmit scheduler: comma training after reset, then two-lane arbitration with idle fill.
// Optional build macro FIXED_PRIORITY_EN makes lane 0 always win instead of round-robin.
module arbitro_serial_tx
  import serial_link_pkg::*;
#(
  parameter int unsigned       TRAIN_WORDS = TRAIN_WORDS_DEF,
  parameter logic [WORD_W-1:0] IDLE_WORD   = IDLE_WORD_DEF
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_in0,
  input  logic              valid_in0,
  output logic              ready0,
  input  logic [WORD_W-1:0] data_in1,
  input  logic              valid_in1,
  output logic              ready1,
  output logic              data_out,
  output logic              word_start,
  output logic              lane_out,
  output logic              idle_out,
  output logic              active
);

  state_t                 state_q, state_d;
  logic [TRAIN_CNT_W-1:0] train_cnt_q, train_cnt_d;
  logic                   rr_q, rr_d;
  logic                   active_d;
  logic                   load_slot_c;
  logic                   arb_slot;
  logic                   grant0, grant1;
  logic [WORD_W-1:0]      load_word;
  logic                   load_lane;
  logic                   load_idle;

  paralelo_serial #(.RESET_WORD(IDLE_WORD)) u_ser (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .load_word   (load_word),
    .load_lane   (load_lane),
    .load_idle   (load_idle),
    .data_out    (data_out),
    .word_start  (word_start),
    .lane_out    (lane_out),
    .idle_out    (idle_out),
    .load_slot_c (load_slot_c)
  );

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= TRAIN;
      train_cnt_q <= '0;
      rr_q        <= 1'b0;
      active      <= 1'b0;
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      rr_q        <= rr_d;
      active      <= active_d;
    end
  end

  // The final training slot already arbitrates so the first data word follows training without a gap.
  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    rr_d        = rr_q;
    active_d    = active;
    arb_slot    = 1'b0;
    load_word   = IDLE_WORD;
    load_lane   = 1'b0;
    load_idle   = 1'b1;
`ifdef FIXED_PRIORITY_EN
    grant0 = valid_in0;
    grant1 = valid_in1 & ~valid_in0;
`else
    grant0 = valid_in0 & (~valid_in1 | ~rr_q);
    grant1 = valid_in1 & (~valid_in0 | rr_q);
`endif
    if (load_slot_c && !reset) begin
      if (state_q == TRAIN) begin
        train_cnt_d = train_cnt_q + TRAIN_CNT_W'(1);
        if (train_cnt_q == TRAIN_CNT_W'(TRAIN_WORDS - 1)) begin
          state_d  = RUN;
          active_d = 1'b1;
          arb_slot = 1'b1;
        end
      end else begin
        arb_slot = 1'b1;
      end
    end
    if (arb_slot) begin
      if (grant0) begin
        load_word = data_in0;
        load_lane = 1'b0;
        load_idle = 1'b0;
      end else if (grant1) begin
        load_word = data_in1;
        load_lane = 1'b1;
        load_idle = 1'b0;
      end
`ifndef FIXED_PRIORITY_EN
      if (valid_in0 && valid_in1) rr_d = ~rr_q;
`endif
    end
  end

  assign ready0 = arb_slot & grant0;
  assign ready1 = arb_slot & grant1;

endmodule
